// File: rtl/vga_pkg.sv
// Shared timing constants and types for the VGA sync generator.
// Defaults describe 640x480@60 Hz with a 25 MHz pixel rate.
package vga_pkg;

   localparam int H_DISPLAY_DEF = 640;
   localparam int H_FP_DEF      = 16;
   localparam int H_SYNC_DEF    = 96;
   localparam int H_BP_DEF      = 48;

   localparam int V_DISPLAY_DEF = 480;
   localparam int V_FP_DEF      = 10;
   localparam int V_SYNC_DEF    = 2;
   localparam int V_BP_DEF      = 33;

   localparam int H_TOTAL_DEF = H_DISPLAY_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
   localparam int V_TOTAL_DEF = V_DISPLAY_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

   localparam int H_SYNC_START_DEF = H_DISPLAY_DEF + H_FP_DEF;
   localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF - 1;
   localparam int V_SYNC_START_DEF = V_DISPLAY_DEF + V_FP_DEF;
   localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF - 1;

   localparam int RGB_W = 3;
   localparam int CNT_W = 10;

   // Bundle that travels through the delay line alongside the renderer latency.
   typedef struct packed {
      logic hsync;
      logic vsync;
      logic video_on;
   } sync_bus_t;

   function automatic logic sync_level(input logic active, input logic pol);
      return active ? pol : ~pol;
   endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register with a synchronous reset value.
// DEPTH = 0 degenerates to a wire.
module sync_delay_line #(
   parameter int               WIDTH     = 3,
   parameter int               DEPTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   generate
      if (DEPTH == 0) begin : g_pass
         assign dout = din;
      end else begin : g_shift
         logic [WIDTH-1:0] stage [DEPTH];

         always_ff @(posedge clk) begin
            if (reset) begin
               for (int i = 0; i < DEPTH; i++) begin
                  stage[i] <= RESET_VAL;
               end
            end else begin
               stage[0] <= din;
               for (int i = 1; i < DEPTH; i++) begin
                  stage[i] <= stage[i-1];
               end
            end
         end

         assign dout = stage[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-enable divider, h/v counters, sync decode,
// and a delay line that keeps sync aligned with renderer colour latency.
module vga_sync_gen
   import vga_pkg::*;
#(
   parameter int CLK_DIV   = 4,
   parameter int H_DISPLAY = H_DISPLAY_DEF,
   parameter int H_FP      = H_FP_DEF,
   parameter int H_SYNC    = H_SYNC_DEF,
   parameter int H_BP      = H_BP_DEF,
   parameter int V_DISPLAY = V_DISPLAY_DEF,
   parameter int V_FP      = V_FP_DEF,
   parameter int V_SYNC    = V_SYNC_DEF,
   parameter int V_BP      = V_BP_DEF,
   parameter int SYNC_POL  = 0,
   parameter int PIPE_DLY  = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [RGB_W-1:0] rgb_in,
   output logic [CNT_W-1:0] pixel_x,
   output logic [CNT_W-1:0] pixel_y,
   output logic             video_on,
   output logic             p_tick,
   output logic             frame_start,
   output logic             hsync,
   output logic             vsync,
   output logic [RGB_W-1:0] rgb
);

   localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_DISP_C = CNT_W'(H_DISPLAY);
   localparam logic [CNT_W-1:0] V_DISP_C = CNT_W'(V_DISPLAY);
   localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_DISPLAY + H_FP);
   localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_DISPLAY + H_FP + H_SYNC - 1);
   localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_DISPLAY + V_FP);
   localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_DISPLAY + V_FP + V_SYNC - 1);

   localparam logic SYNC_ACT = (SYNC_POL != 0);
   localparam logic [2:0] IDLE_BUS = {~SYNC_ACT, ~SYNC_ACT, 1'b0};

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_cnt;
   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;
   logic             h_last;
   logic             v_last;
   logic             hs_act;
   logic             vs_act;
   sync_bus_t        raw_bus;
   sync_bus_t        dly_bus;

   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt <= '0;
      end else if (p_tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   // With no division the pixel enable is simply always on.
   generate
      if (CLK_DIV == 1) begin : g_tick_const
         assign p_tick = 1'b1;
      end else begin : g_tick_cmp
         assign p_tick = (div_cnt == DIV_LAST);
      end
   endgenerate

   assign h_last = (h_cnt == H_LAST);
   assign v_last = (v_cnt == V_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         h_cnt       <= '0;
         v_cnt       <= '0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= p_tick & h_last & v_last;
         if (p_tick) begin
            if (h_last) begin
               h_cnt <= '0;
               v_cnt <= v_last ? '0 : v_cnt + 1'b1;
            end else begin
               h_cnt <= h_cnt + 1'b1;
            end
         end
      end
   end

   assign pixel_x  = h_cnt;
   assign pixel_y  = v_cnt;
   assign video_on = (h_cnt < H_DISP_C) && (v_cnt < V_DISP_C);

   assign hs_act = (h_cnt >= HS_START) && (h_cnt <= HS_END);
   assign vs_act = (v_cnt >= VS_START) && (v_cnt <= VS_END);

   always_comb begin
      raw_bus          = '0;
      raw_bus.hsync    = sync_level(hs_act, SYNC_ACT);
      raw_bus.vsync    = sync_level(vs_act, SYNC_ACT);
      raw_bus.video_on = video_on;
   end

   // Delays run on every clk so the alignment is in clk cycles, matching
   // renderer ROM latency rather than pixel periods.
   sync_delay_line #(
      .WIDTH     (3),
      .DEPTH     (PIPE_DLY),
      .RESET_VAL (IDLE_BUS)
   ) u_sync_delay_line (
      .clk   (clk),
      .reset (reset),
      .din   (raw_bus),
      .dout  (dly_bus)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         hsync <= ~SYNC_ACT;
         vsync <= ~SYNC_ACT;
         rgb   <= '0;
      end else begin
         hsync <= dly_bus.hsync;
         vsync <= dly_bus.vsync;
         rgb   <= dly_bus.video_on ? rgb_in : '0;
      end
   end

endmodule
